// File: rtl/tt_addon_pkg.sv
// Shared widths, FSM state type and saturation limit for the magnitude block.
package tt_addon_pkg;

  localparam int unsigned IN_W   = 8;
  localparam int unsigned SUM_W  = 17;
  localparam int unsigned ROOT_W = 9;

  localparam logic [IN_W-1:0] SAT_MAX = 8'd255;

  typedef enum logic [1:0] {
    StLoad,
    StRoot,
    StDone
  } state_e;

endpackage

// File: rtl/isqrt_iter.sv
// Bit-serial integer square root, one result bit per clock, MSB first.
// Tracks root^2 alongside root so each trial square is formed with shifts and adds only.
module isqrt_iter
  import tt_addon_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [SUM_W-1:0]  radicand_i,
  output logic              done_o,
  output logic [ROOT_W-1:0] root_o
);

  localparam int unsigned SqW = SUM_W + 1;

  logic [3:0]        k_q, k_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [SqW-1:0]    sq_q, sq_d;
  logic [SqW-1:0]    trial_sq;
  logic              busy_q, busy_d;

  always_comb begin
    // (root + 2^k)^2 = root^2 + root*2^(k+1) + 4^k
    trial_sq = sq_q
             + ({{(SqW - ROOT_W){1'b0}}, root_q} << (k_q + 4'd1))
             + (SqW'(1) << {k_q, 1'b0});
    k_d    = k_q;
    root_d = root_q;
    sq_d   = sq_q;
    busy_d = busy_q;
    if (start_i) begin
      k_d    = 4'(ROOT_W - 1);
      root_d = '0;
      sq_d   = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial_sq <= {1'b0, radicand_i}) begin
        root_d = root_q | (ROOT_W'(1) << k_q);
        sq_d   = trial_sq;
      end
      if (k_q == 4'd0) begin
        busy_d = 1'b0;
      end else begin
        k_d = k_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_q    <= '0;
      root_q <= '0;
      sq_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      root_q <= root_d;
      sq_q   <= sq_d;
      busy_q <= busy_d;
    end
  end

  // High during the cycle whose edge resolves the last root bit.
  assign done_o = busy_q && (k_q == 4'd0);
  assign root_o = root_q;

endmodule

// File: rtl/tt_um_addon.sv
// Tiny Tapeout block: uo_out = min(255, floor(sqrt(x^2 + y^2))), x on ui_in, y on uio_in.
module tt_um_addon
  import tt_addon_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e            state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [IN_W-1:0]   uo_q, uo_d;
  logic              start;
  logic              root_done;
  logic [ROOT_W-1:0] root;

  isqrt_iter u_isqrt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .radicand_i (sum_q),
    .done_o     (root_done),
    .root_o     (root)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    uo_d    = uo_q;
    start   = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (ena) begin
          sum_d   = SUM_W'(ui_in) * SUM_W'(ui_in) + SUM_W'(uio_in) * SUM_W'(uio_in);
          start   = 1'b1;
          state_d = StRoot;
        end
      end
      StRoot: begin
        if (root_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        uo_d    = (root[ROOT_W-1:IN_W] != '0) ? SAT_MAX : root[IN_W-1:0];
        state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      sum_q   <= '0;
      uo_q    <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      uo_q    <= uo_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_addon.sv
// Directed bench for tt_um_addon: reset, latency, triples, truncation, saturation, hold, aborts.
module tb_tt_um_addon;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tt_um_addon dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input logic [7:0] x, input logic [7:0] y);
    ui_in  = x;
    uio_in = y;
  endtask

  // Bounded wait for uo_out to reach exp, then one comparison.
  task automatic wait_for(input string tag, input logic [7:0] exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (uo_out === exp) break;
    end
    chk(tag, uo_out, exp);
  endtask

  initial begin
    logic [7:0] seen;
    rst_n = 1'b0;
    ena   = 1'b1;
    apply(8'd3, 8'd4);
    cycles(3);
    chk("rst_uo_out", uo_out, 8'd0);
    chk("rst_uio_out", uio_out, 8'd0);
    chk("rst_uio_oe", uio_oe, 8'd0);

    // First edge after release is LOAD; DONE lands on the 11th edge.
    rst_n = 1'b1;
    cycles(10);
    chk("latency_before", uo_out, 8'd0);
    cycles(1);
    chk("latency_3_4", uo_out, 8'd5);

    apply(8'd5, 8'd12);   wait_for("tri_5_12", 8'd13, 22);
    apply(8'd6, 8'd8);    wait_for("tri_6_8", 8'd10, 22);
    apply(8'd7, 8'd24);   wait_for("tri_7_24", 8'd25, 22);
    apply(8'd0, 8'd0);    wait_for("zero", 8'd0, 22);

    apply(8'd1, 8'd1);    wait_for("trunc_1_1", 8'd1, 22);
    apply(8'd255, 8'd255); wait_for("sat_255_255", 8'd255, 22);
    apply(8'd2, 8'd3);    wait_for("trunc_2_3", 8'd3, 22);
    apply(8'd255, 8'd128); wait_for("sat_255_128", 8'd255, 22);
    apply(8'd10, 8'd10);  wait_for("trunc_10_10", 8'd14, 22);
    apply(8'd181, 8'd180); wait_for("edge_181_180", 8'd255, 22);

    apply(8'd5, 8'd12);   wait_for("hold_setup", 8'd13, 22);
    ena = 1'b0;
    apply(8'd3, 8'd4);
    seen = 8'd13;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uo_out !== 8'd13) seen = uo_out;
    end
    chk("hold_ena_low", seen, 8'd13);
    ena = 1'b1;
    wait_for("reenable", 8'd5, 22);

    // Known phase after a reset release: inputs change mid-ROOT.
    rst_n = 1'b0;
    cycles(1);
    apply(8'd6, 8'd8);
    rst_n = 1'b1;
    cycles(4);
    apply(8'd7, 8'd24);
    cycles(7);
    chk("old_result_first", uo_out, 8'd10);
    cycles(10);
    chk("old_result_held", uo_out, 8'd10);
    cycles(1);
    chk("new_result", uo_out, 8'd25);

    cycles(3);
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid_root", uo_out, 8'd0);
    apply(8'd5, 8'd12);
    @(negedge clk);
    chk("reset_held", uo_out, 8'd0);
    rst_n = 1'b1;
    wait_for("after_reset_pulse", 8'd13, 22);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
